// File: rtl/evt_counter_bank_pkg.sv
// evt_counter_pkg: shared helpers and constants for the event counter bank.
// Provides clog2_min1 for select widths and the count-mode encodings.
package evt_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Width of a select field that picks one of n items; never below 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evt_counter_bank_sync_edge.sv
// evt_sync_edge: synchronises one async blip line and flags its rising edge.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset, async_i raw
//   line, arm_i enables detection (warm-up done), rise_o one-cycle edge pulse.
module evt_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic async_i,
    input  logic arm_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev_q tracks the sync output even while disarmed, so a line that is
    // already high when detection arms is never seen as an edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = arm_i & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/evt_counter_bank.sv
// evt_counter_bank: N_CH synchronised event counters (wrap/saturate), sticky
// overflow flags, atomic snapshot into shadows and a registered byte readout.
// Ports: wb_clk_i, wb_rst_ni (async low); event_i blip lines; en_i count
//   enable; clear_i sync clear; sat_mode_i; snap_i snapshot pulse;
//   ch_sel_i/byte_sel_i readout select; data_o slice; ovf_o; snap_valid_o.
// Optional: define EVT_COUNTER_BANK_THRESH_EN to add thresh_i and sticky irq_o.
module evt_counter_bank
    import evt_counter_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int OUT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_ni,
    input  logic [N_CH-1:0]                      event_i,
    input  logic                                 en_i,
    input  logic                                 clear_i,
    input  logic                                 sat_mode_i,
    input  logic                                 snap_i,
    input  logic [clog2_min1(N_CH)-1:0]          ch_sel_i,
    input  logic [clog2_min1(CNT_W/OUT_W)-1:0]   byte_sel_i,
    output logic [OUT_W-1:0]                     data_o,
    output logic [N_CH-1:0]                      ovf_o,
`ifdef EVT_COUNTER_BANK_THRESH_EN
    input  logic [CNT_W-1:0]                     thresh_i,
    output logic                                 irq_o,
`endif
    output logic                                 snap_valid_o
);

    localparam int CH_W = clog2_min1(N_CH);
    localparam int N_SL = CNT_W / OUT_W;
    localparam int BS_W = clog2_min1(N_SL);
    localparam int WU_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(SYNC_STAGES + 1);

    logic [WU_W-1:0]             wu_q, wu_d;
    logic                        arm;
    logic [N_CH-1:0]             rise;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0][CNT_W-1:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]             ovf_q, ovf_d;
    logic                        snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]            sel_cnt;
    logic [OUT_W-1:0]            data_q, data_d;

    // Warm-up: hold detection off until the sync chain and edge register
    // hold real samples of the lines.
    assign arm  = (wu_q == WU_DONE);
    assign wu_d = arm ? wu_q : wu_q + WU_W'(1);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        evt_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .wb_clk_i (wb_clk_i),
            .wb_rst_ni(wb_rst_ni),
            .async_i  (event_i[c]),
            .arm_i    (arm),
            .rise_o   (rise[c])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int c = 0; c < N_CH; c++) begin
            if (clear_i) begin
                cnt_d[c] = '0;
                ovf_d[c] = 1'b0;
            end else if (en_i && rise[c]) begin
                if (cnt_q[c] != '1) begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end else begin
                    ovf_d[c] = 1'b1;
                    cnt_d[c] = (sat_mode_i == MODE_SAT) ? cnt_q[c] : '0;
                end
            end
        end
    end

    // Shadows take the pre-update counters; snap outranks clear on the flag.
    always_comb begin
        shadow_d     = snap_i ? cnt_q : shadow_q;
        snap_valid_d = snap_valid_q;
        if (snap_i) begin
            snap_valid_d = 1'b1;
        end else if (clear_i) begin
            snap_valid_d = 1'b0;
        end
    end

    // Loop-based mux so out-of-range selects fall through to zero.
    always_comb begin
        sel_cnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel_i == CH_W'(c)) begin
                sel_cnt = shadow_q[c];
            end
        end
        data_d = '0;
        for (int b = 0; b < N_SL; b++) begin
            if (byte_sel_i == BS_W'(b)) begin
                data_d = sel_cnt[b*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wu_q         <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            wu_q         <= wu_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            ovf_q        <= ovf_d;
            snap_valid_q <= snap_valid_d;
            data_q       <= data_d;
        end
    end

    assign data_o       = data_q;
    assign ovf_o        = ovf_q;
    assign snap_valid_o = snap_valid_q;

`ifdef EVT_COUNTER_BANK_THRESH_EN
    logic irq_q, irq_d;

    // Fires only on a real change into the threshold, so a saturated
    // counter parked at the threshold does not retrigger.
    always_comb begin
        irq_d = irq_q;
        if (clear_i) begin
            irq_d = 1'b0;
        end else if (thresh_i != '0) begin
            for (int c = 0; c < N_CH; c++) begin
                if (cnt_d[c] != cnt_q[c] && cnt_d[c] == thresh_i) begin
                    irq_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_evt_counter_bank.sv
// tb_evt_counter_bank: directed test of two evt_counter_bank builds
// (4 ch x 8 bit, 3 ch x 16 bit) sharing stimulus.
module tb_evt_counter_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, sat, snap;
    logic [3:0] ev;
    logic [1:0] ch_sel;
    logic       byte_sel;
    logic [7:0] data_a, data_b;
    logic [3:0] ovf_a;
    logic [2:0] ovf_b;
    logic       sv_a, sv_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    evt_counter_bank #(
        .N_CH(4), .CNT_W(8), .OUT_W(8), .SYNC_STAGES(2)
    ) u_a (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .event_i     (ev),
        .en_i        (en),
        .clear_i     (clr),
        .sat_mode_i  (sat),
        .snap_i      (snap),
        .ch_sel_i    (ch_sel),
        .byte_sel_i  (byte_sel),
        .data_o      (data_a),
        .ovf_o       (ovf_a),
        .snap_valid_o(sv_a)
    );

    evt_counter_bank #(
        .N_CH(3), .CNT_W(16), .OUT_W(8), .SYNC_STAGES(2)
    ) u_b (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .event_i     (ev[2:0]),
        .en_i        (en),
        .clear_i     (clr),
        .sat_mode_i  (sat),
        .snap_i      (snap),
        .ch_sel_i    (ch_sel),
        .byte_sel_i  (byte_sel),
        .data_o      (data_b),
        .ovf_o       (ovf_b),
        .snap_valid_o(sv_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            ev = ev | m;
            cyc(3);
            ev = ev & ~m;
            cyc(3);
        end
    endtask

    task automatic do_snap();
        snap = 1'b1;
        cyc(1);
        snap = 1'b0;
        cyc(2);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
    endtask

    task automatic rd(input logic [1:0] c, input logic b);
        ch_sel   = c;
        byte_sel = b;
        cyc(2);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; sat = 1'b0; snap = 1'b0;
        ev = 4'b0001; ch_sel = 2'd0; byte_sel = 1'b0;

        // Reset, ch0 held high across release
        cyc(3);
        chk("rst_data_a", data_a, 8'h00);
        chk("rst_data_b", data_b, 8'h00);
        chk("rst_ovf_a", ovf_a, 4'h0);
        chk("rst_sv_a", sv_a, 1'b0);
        chk("rst_sv_b", sv_b, 1'b0);
        rst_n = 1'b1;
        cyc(20);
        do_snap();
        chk("warm_data_a", data_a, 8'h00);
        chk("warm_data_b", data_b, 8'h00);
        chk("warm_ovf_a", ovf_a, 4'h0);
        chk("warm_sv_a", sv_a, 1'b1);
        ev = 4'b0000;
        cyc(4);

        // Latency: ch1 high sampled at edge k, count visible after k+2
        ch_sel = 2'd1; byte_sel = 1'b0;
        ev[1] = 1'b1;               // t0, before edge k
        cyc(2);                     // t2, before edge k+2
        snap = 1'b1;
        cyc(1);                     // t3
        ev[1] = 1'b0;
        cyc(1);                     // t4: data from snap at k+2
        snap = 1'b0;
        chk("lat_k2_a", data_a, 8'h00);
        chk("lat_k2_b", data_b, 8'h00);
        cyc(1);                     // t5: data from snap at k+3
        chk("lat_k3_a", data_a, 8'h01);
        chk("lat_k3_b", data_b, 8'h01);
        rd(2'd1, 1'b1);
        chk("lat_hi_a_oor", data_a, 8'h00);
        chk("lat_hi_b", data_b, 8'h00);
        cyc(3);

        // Wrap mode, 256 pulses on ch2
        do_clear();
        chk("clr_sv_a", sv_a, 1'b0);
        sat = 1'b0;
        pulse(4'b0100, 256);
        cyc(2);
        do_snap();
        rd(2'd2, 1'b0);
        chk("wrap_a", data_a, 8'h00);
        chk("wrap_ovf_a", ovf_a, 4'b0100);
        chk("wrap_b_lo", data_b, 8'h00);
        chk("wrap_ovf_b", ovf_b, 3'b000);
        rd(2'd2, 1'b1);
        chk("wrap_b_hi", data_b, 8'h01);
        chk("wrap_a_oor", data_a, 8'h00);

        // Saturate mode
        do_clear();
        chk("clr_ovf_a", ovf_a, 4'h0);
        sat = 1'b1;
        pulse(4'b0100, 256);
        cyc(2);
        do_snap();
        rd(2'd2, 1'b0);
        chk("sat_a", data_a, 8'hFF);
        chk("sat_ovf_a", ovf_a, 4'b0100);
        chk("sat_b_lo", data_b, 8'h00);
        pulse(4'b0100, 10);
        cyc(2);
        do_snap();
        chk("sat10_a", data_a, 8'hFF);
        chk("sat10_b_lo", data_b, 8'h0A);
        en = 1'b0;
        pulse(4'b0100, 3);
        cyc(2);
        do_snap();
        chk("en0_b_lo", data_b, 8'h0A);
        en = 1'b1;
        sat = 1'b0;

        // Collision: clear + snap + ch0 edge in one cycle, ch0 at 5
        do_clear();
        rd(2'd0, 1'b0);
        pulse(4'b0001, 5);
        ev[0] = 1'b1;               // t0
        cyc(2);                     // t2, edge k+2 carries the rise
        clr = 1'b1; snap = 1'b1;
        cyc(1);                     // t3
        clr = 1'b0; snap = 1'b0;
        ev[0] = 1'b0;
        cyc(1);                     // t4
        chk("col_shadow_a", data_a, 8'h05);
        chk("col_shadow_b", data_b, 8'h05);
        chk("col_sv_a", sv_a, 1'b1);
        chk("col_ovf_a", ovf_a, 4'h0);
        cyc(3);
        do_snap();
        chk("col_cnt_a", data_a, 8'h00);
        chk("col_cnt_b", data_b, 8'h00);

        // Simultaneous edges on ch1 and ch3
        pulse(4'b1010, 1);
        cyc(2);
        do_snap();
        rd(2'd1, 1'b0);
        chk("multi_ch1_a", data_a, 8'h01);
        chk("multi_ch1_b", data_b, 8'h01);
        rd(2'd3, 1'b0);
        chk("multi_ch3_a", data_a, 8'h01);
        chk("multi_ch3_b_oor", data_b, 8'h00);

        // Async reset mid-count
        do_clear();
        rd(2'd0, 1'b0);
        pulse(4'b0001, 7);
        cyc(2);
        do_snap();
        chk("pre_rst_a", data_a, 8'h07);
        chk("pre_rst_b", data_b, 8'h07);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_a", data_a, 8'h00);
        chk("arst_data_b", data_b, 8'h00);
        chk("arst_sv_a", sv_a, 1'b0);
        chk("arst_sv_b", sv_b, 1'b0);
        chk("arst_ovf_a", ovf_a, 4'h0);
        #2 rst_n = 1'b1;
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
